// File: rtl/mio_bus_ws_if.sv
// CPU-side bus, data-RAM port and peripheral-channel port of the wait-state bus bridge.
// The slave modport is the bridge's view; the master modport is the surrounding system.
interface mio_bus_ws_if #(
    parameter int RAM_AW = 10,
    parameter int NCH    = 4
) ();
    logic                  cpu_req;
    logic                  mem_w;
    logic [31:0]           addr_bus;
    logic [31:0]           Cpu_data2bus;
    logic [31:0]           Cpu_data4bus;
    logic                  bus_ready;
    logic                  bus_err;
    logic [RAM_AW-1:0]     ram_addr;
    logic [31:0]           ram_data_in;
    logic [31:0]           ram_data_out;
    logic                  data_ram_we;
    logic [NCH-1:0]        per_sel;
    logic                  per_we;
    logic [7:0]            per_off;
    logic [31:0]           Peripheral_in;
    logic [32*NCH-1:0]     per_rdata;
    logic [NCH-1:0]        per_ack;
    logic [7:0]            err_count;

    modport slave (
        input  cpu_req, mem_w, addr_bus, Cpu_data2bus, ram_data_out, per_rdata, per_ack,
        output Cpu_data4bus, bus_ready, bus_err, ram_addr, ram_data_in, data_ram_we,
               per_sel, per_we, per_off, Peripheral_in, err_count
    );

    modport master (
        output cpu_req, mem_w, addr_bus, Cpu_data2bus, ram_data_out, per_rdata, per_ack,
        input  Cpu_data4bus, bus_ready, bus_err, ram_addr, ram_data_in, data_ram_we,
               per_sel, per_we, per_off, Peripheral_in, err_count
    );
endinterface

// File: rtl/mio_bus_ws.sv
// Bus bridge: decodes a CPU access to the data RAM (fixed wait states) or to one of NCH
// acknowledge-driven peripheral channels, and returns one bus_ready strobe per access.
module mio_bus_ws #(
    parameter int RAM_AW   = 10,
    parameter int NCH      = 4,
    parameter int WAIT_RAM = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic           clk,
    input  logic           rst,
    mio_bus_ws_if.slave    bus
);
    localparam int CNT_MAX = (WAIT_RAM > TIMEOUT) ? WAIT_RAM : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, RAM, PER, RESP} state_t;

    state_t            state_q, state_d;
    logic [RAM_AW-1:0] waddr_q, waddr_d;
    logic [7:0]        off_q, off_d;
    logic [3:0]        ch_q, ch_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        errcnt_q, errcnt_d;

    logic [3:0]        sel_ch;
    logic              misal, hit_ram, hit_per, dec_err;
    logic              in_ram, in_per;
    logic              ack_hit;
    logic [31:0]       rdata_hit;
    logic [NCH-1:0]    per_sel_v;

    assign sel_ch  = bus.addr_bus[11:8];
    assign misal   = (bus.addr_bus[1:0] != 2'b00);
    assign hit_ram = (bus.addr_bus[31:28] == 4'h0);
    assign hit_per = (bus.addr_bus[31:12] == 20'hffff0) && (sel_ch != 4'd0) && (sel_ch <= 4'(NCH));
    assign dec_err = misal || !(hit_ram || hit_per);

    assign in_ram  = (state_q == RAM);
    assign in_per  = (state_q == PER);

    // Only the latched channel's ack and read data are visible; other channels are ignored.
    always_comb begin
        ack_hit   = 1'b0;
        rdata_hit = '0;
        per_sel_v = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_q == 4'(k)) begin
                ack_hit      = bus.per_ack[k];
                rdata_hit    = bus.per_rdata[32*k +: 32];
                per_sel_v[k] = in_per;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        off_d    = off_q;
        ch_d     = ch_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        errcnt_d = errcnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    waddr_d = bus.addr_bus[RAM_AW+1:2];
                    off_d   = bus.addr_bus[7:0];
                    ch_d    = sel_ch - 4'd1;
                    wdata_d = bus.Cpu_data2bus;
                    we_d    = bus.mem_w;
                    cnt_d   = '0;
                    err_d   = dec_err;
                    if (dec_err) begin
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = hit_ram ? RAM : PER;
                    end
                end
            end
            RAM: begin
                if (cnt_q == CNT_W'(WAIT_RAM - 1)) begin
                    rdata_d = we_q ? 32'd0 : bus.ram_data_out;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PER: begin
                // An ack arriving on the timeout cycle still completes without error.
                if (ack_hit) begin
                    rdata_d = we_q ? 32'd0 : rdata_hit;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                if (err_q && (errcnt_q != 8'hff)) begin
                    errcnt_d = errcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            waddr_q  <= '0;
            off_q    <= '0;
            ch_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            off_q    <= off_d;
            ch_q     <= ch_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Strobes are gated by state so an asynchronous reset drops them at once.
    assign bus.bus_ready     = (state_q == RESP);
    assign bus.bus_err       = (state_q == RESP) && err_q;
    assign bus.Cpu_data4bus  = rdata_q;
    assign bus.ram_addr      = in_ram ? waddr_q : '0;
    assign bus.ram_data_in   = in_ram ? wdata_q : '0;
    assign bus.data_ram_we   = in_ram && we_q && (cnt_q == '0);
    assign bus.per_sel       = per_sel_v;
    assign bus.per_we        = in_per && we_q;
    assign bus.per_off       = in_per ? off_q : '0;
    assign bus.Peripheral_in = in_per ? wdata_q : '0;
    assign bus.err_count     = errcnt_q;
endmodule

// File: tb/tb_mio_bus_ws.sv
// Self-checking bench for mio_bus_ws: directed scenarios plus random accesses checked
// against a transaction-level model of the decode, wait-state and timeout rules.
module tb_mio_bus_ws;
    localparam int RAM_AW   = 10;
    localparam int NCH      = 4;
    localparam int WAIT_RAM = 1;
    localparam int TIMEOUT  = 15;
    localparam int DEPTH    = 1 << RAM_AW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mio_bus_ws_if #(.RAM_AW(RAM_AW), .NCH(NCH)) bus ();

    mio_bus_ws #(.RAM_AW(RAM_AW), .NCH(NCH), .WAIT_RAM(WAIT_RAM), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Environment RAM attached to the DUT, and the model's own copy of memory contents.
    logic [31:0] env_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    assign bus.ram_data_out = env_mem[bus.ram_addr];
    always @(posedge clk) begin
        if (bus.data_ram_we) env_mem[bus.ram_addr] <= bus.ram_data_in;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_errs = 0;
    logic [31:0] last_rd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access: wait for IDLE, request, follow every cycle, check the response.
    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input int ack_cyc, input logic [31:0] pdata);
        logic [31:0]    prd [NCH];
        logic [NCH-1:0] ack_v;
        logic [31:0]    exp_rd, exp_sel;
        logic           misal, is_ram, per_ok, err;
        int             ch, exp_lat, lat, we_cyc;
        bit             done;

        misal  = (a[1:0] != 2'b00);
        is_ram = (a[31:28] == 4'h0);
        ch     = int'(a[11:8]) - 1;
        per_ok = (a[31:12] == 20'hffff0) && (ch >= 0) && (ch < NCH);
        err    = misal || !(is_ram || per_ok);
        for (int k = 0; k < NCH; k++) prd[k] = $urandom;
        if (per_ok) prd[ch] = pdata;

        exp_sel = '0;
        if (err) begin
            exp_lat = 1;
            exp_rd  = '0;
        end else if (is_ram) begin
            exp_lat = WAIT_RAM + 1;
            exp_rd  = w ? 32'd0 : ref_mem[a[RAM_AW+1:2]];
            if (w) ref_mem[a[RAM_AW+1:2]] = d;
        end else begin
            exp_sel = 32'(1) << ch;
            if (ack_cyc >= 1 && ack_cyc <= TIMEOUT) begin
                exp_lat = ack_cyc + 1;
                exp_rd  = w ? 32'd0 : prd[ch];
            end else begin
                err     = 1'b1;
                exp_lat = TIMEOUT + 1;
                exp_rd  = '0;
            end
        end

        @(posedge clk);
        @(negedge clk);
        check("idle_ready", 32'(bus.bus_ready), 32'd0);
        check("hold_rdata", bus.Cpu_data4bus, last_rd);
        check("err_count", 32'(bus.err_count), 32'(exp_errs));
        for (int k = 0; k < NCH; k++) bus.per_rdata[32*k +: 32] = prd[k];
        bus.per_ack      = '0;
        bus.cpu_req      = 1'b1;
        bus.addr_bus     = a;
        bus.mem_w        = w;
        bus.Cpu_data2bus = d;
        @(posedge clk);

        lat    = 0;
        we_cyc = 0;
        done   = 1'b0;
        for (int c = 1; c <= TIMEOUT + WAIT_RAM + 8 && !done; c++) begin
            @(negedge clk);
            bus.cpu_req      = 1'b0;
            bus.addr_bus     = $urandom;
            bus.mem_w        = 1'($urandom);
            bus.Cpu_data2bus = $urandom;
            if (bus.data_ram_we) we_cyc++;
            if (bus.bus_ready) begin
                done = 1'b1;
                lat  = c;
                check("resp_per_sel", 32'(bus.per_sel), 32'd0);
            end else begin
                check("busy_per_sel", 32'(bus.per_sel), exp_sel);
                check("busy_hold_rdata", bus.Cpu_data4bus, last_rd);
                if (is_ram && !err) begin
                    check("ram_addr", 32'(bus.ram_addr), 32'(a[RAM_AW+1:2]));
                    if (w) check("ram_data_in", bus.ram_data_in, d);
                end
                if (per_ok) begin
                    check("per_we", 32'(bus.per_we), 32'(w));
                    check("per_off", 32'(bus.per_off), 32'(a[7:0]));
                    check("per_wdata", bus.Peripheral_in, d);
                end
                ack_v = NCH'($urandom);
                if (per_ok) ack_v[ch] = (c == ack_cyc);
                bus.per_ack = ack_v;
            end
        end
        bus.per_ack = '0;

        check("latency", 32'(lat), 32'(exp_lat));
        check("bus_err", 32'(bus.bus_err), 32'(err));
        check("rdata", bus.Cpu_data4bus, exp_rd);
        check("ram_we_cycles", 32'(we_cyc), (is_ram && !err && w) ? 32'd1 : 32'd0);
        last_rd = exp_rd;
        if (err && exp_errs < 255) exp_errs++;
    endtask

    initial begin
        logic [31:0] a;
        int          kind, ch, nib;

        bus.cpu_req      = 1'b1;
        bus.mem_w        = 1'b1;
        bus.addr_bus     = 32'h0000_0004;
        bus.Cpu_data2bus = 32'h1234_5678;
        bus.per_rdata    = '0;
        bus.per_ack      = '1;
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end

        // Reset holds everything quiet even with a request and acks present.
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.bus_ready), 32'd0);
        check("rst_err", 32'(bus.bus_err), 32'd0);
        check("rst_rdata", bus.Cpu_data4bus, 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_ram_we", 32'(bus.data_ram_we), 32'd0);
        check("rst_ram_wdata", bus.ram_data_in, 32'd0);
        check("rst_per_sel", 32'(bus.per_sel), 32'd0);
        check("rst_per_we", 32'(bus.per_we), 32'd0);
        check("rst_per_off", 32'(bus.per_off), 32'd0);
        check("rst_per_wdata", bus.Peripheral_in, 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        bus.cpu_req = 1'b0;
        bus.per_ack = '0;
        rst = 1'b1;

        // Directed scenarios.
        env_mem[1] = 32'hffff_eeee;
        ref_mem[1] = 32'hffff_eeee;
        txn(32'h0000_0004, 1'b0, 32'h0, 0, 32'h0);
        txn(32'h0000_0008, 1'b1, 32'heeee_aaaa, 0, 32'h0);
        check("env_mem2", env_mem[2], 32'heeee_aaaa);
        txn(32'h0000_0008, 1'b0, 32'h0, 0, 32'h0);
        txn(32'hffff_0210, 1'b0, 32'h0, 3, 32'h1234_5678);
        txn(32'hffff_021a, 1'b0, 32'h0, 1, 32'h0);
        txn(32'h3c08_ffff, 1'b0, 32'h0, 1, 32'h0);
        txn(32'hffff_0100, 1'b0, 32'h0, 0, 32'h5555_aaaa);
        txn(32'hffff_0100, 1'b0, 32'h0, TIMEOUT, 32'habcd_ef01);
        txn(32'hffff_0100, 1'b0, 32'h0, TIMEOUT + 1, 32'habcd_ef01);
        txn(32'hffff_0304, 1'b1, 32'hdead_beef, 2, 32'h0);
        txn(32'hffff_0004, 1'b0, 32'h0, 1, 32'h0);
        txn(32'hffff_0500, 1'b0, 32'h0, 1, 32'h0);

        // Randomized mix of RAM, peripheral, misaligned and unmapped accesses.
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 5);
            ch   = $urandom_range(0, NCH - 1);
            a    = '0;
            case (kind)
                0: a = ($urandom & 32'h0fff_f000) | (32'($urandom_range(0, 63)) << 2);
                1: a = ($urandom & 32'h0fff_f0fc) | 32'($urandom_range(1, 3));
                2, 3: a = {20'hffff0, 4'(ch + 1), 8'($urandom) & 8'hfc};
                4: begin
                    nib = $urandom_range(NCH + 1, 16);
                    if (nib == 16) nib = 0;
                    a = {20'hffff0, 4'(nib), 8'($urandom) & 8'hfc};
                end
                default: a = {4'($urandom_range(1, 14)), 28'($urandom) & 28'hfff_fffc};
            endcase
            txn(a, 1'($urandom), $urandom, $urandom_range(1, TIMEOUT + 3), $urandom);
        end

        // Reset in the middle of a peripheral access.
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.addr_bus = 32'hffff_0200;
        bus.mem_w    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        check("midrst_pre_sel", 32'(bus.per_sel), 32'h2);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_sel", 32'(bus.per_sel), 32'd0);
        check("midrst_ready", 32'(bus.bus_ready), 32'd0);
        check("midrst_err_count", 32'(bus.err_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_ready", 32'(bus.bus_ready), 32'd0);
        end
        last_rd  = '0;
        exp_errs = 0;
        txn(32'h0000_0004, 1'b0, 32'h0, 0, 32'h0);
        txn(32'hffff_0200, 1'b0, 32'h0, 2, 32'h0bad_cafe);

        // Drive the error counter into saturation.
        for (int i = 0; i < 258; i++) txn(32'h0000_0001, 1'b0, 32'h0, 1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("err_count_sat", 32'(bus.err_count), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mio_bus_ws.md
MIO_BUS_WS -- requirements
Module: mio_bus_ws

Interface
REQ-001 Parameter RAM_AW, default 10: data-RAM word-address width.
REQ-002 Parameter NCH, default 4, range 1..15: number of peripheral channels.
REQ-003 Parameter WAIT_RAM, default 1, minimum 1: RAM access cycles.
REQ-004 Parameter TIMEOUT, default 15, minimum 1: peripheral ack timeout in cycles.
REQ-005 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous, active-low.
REQ-007 Port cpu_req, input, 1: access request.
REQ-008 Port mem_w, input, 1: 1 = write.
REQ-009 Port addr_bus, input, 32: byte address.
REQ-010 Port Cpu_data2bus, input, 32: write data.
REQ-011 Port Cpu_data4bus, output, 32: read data.
REQ-012 Port bus_ready, output, 1: one-cycle completion strobe.
REQ-013 Port bus_err, output, 1: error flag, valid with bus_ready.
REQ-014 Port ram_addr, output, RAM_AW: RAM word address.
REQ-015 Port ram_data_in, output, 32: RAM write data.
REQ-016 Port ram_data_out, input, 32: RAM read data.
REQ-017 Port data_ram_we, output, 1: RAM write enable.
REQ-018 Port per_sel, output, NCH: one-hot peripheral select.
REQ-019 Port per_we, output, 1: peripheral write.
REQ-020 Port per_off, output, 8: register offset within channel.
REQ-021 Port Peripheral_in, output, 32: peripheral write data.
REQ-022 Port per_rdata, input, 32*NCH: channel k read data in bits [32k+31:32k].
REQ-023 Port per_ack, input, NCH: per-channel acknowledge.
REQ-024 Port err_count, output, 8: saturating error counter.

Function
REQ-025 Decode: RAM if addr_bus[31:28]=0, word index addr_bus[RAM_AW+1:2]; channel k if addr_bus[31:12]=20'hffff0 and addr_bus[11:8]=k+1 with k<NCH, offset addr_bus[7:0]; anything else is unmapped.
REQ-026 Misaligned (addr_bus[1:0]!=0) or unmapped access SHALL be an error.
REQ-027 FSM states IDLE, RAM, PER, RESP; cpu_req is sampled only in IDLE.
REQ-028 IDLE with cpu_req=1: latch addr, data, mem_w; next state RAM, PER, or RESP with error, by decode.
REQ-029 RAM: lasts exactly WAIT_RAM cycles; ram_addr and ram_data_in driven from latched values; data_ram_we=1 only in the first RAM cycle of a write.
REQ-030 RAM: on the edge ending the last RAM cycle, capture ram_data_out (reads only) and go to RESP.
REQ-031 PER: per_sel[k]=1 and per_we=latched mem_w held until exit; per_off and Peripheral_in stable throughout.
REQ-032 PER exit: per_ack[k]=1 captures that channel's per_rdata slice and goes to RESP; acks on other channels are ignored.
REQ-033 PER timeout: after TIMEOUT cycles without ack, go to RESP with error; if ack and timeout coincide, the ack wins and there is no error.
REQ-034 RESP: exactly one cycle with bus_ready=1; Cpu_data4bus holds captured data (0 on writes and errors); bus_err=1 on error; next state IDLE.
REQ-035 Cpu_data4bus SHALL hold its value until the next RESP.
REQ-036 Errors SHALL assert no RAM or peripheral strobes.
REQ-037 err_count increments on each error RESP and saturates at 255.
REQ-038 Back-to-back: a request is accepted in the IDLE cycle following RESP; a RAM read completes with bus_ready WAIT_RAM+1 cycles after the acceptance edge.

Reset
REQ-039 rst=0 SHALL immediately force IDLE, with all outputs 0, err_count=0, and counters and latches cleared.
REQ-040 Reset during RAM or PER SHALL abort the access with no bus_ready; strobes drop asynchronously.

Verification
REQ-041 Read addr 0x00000004 with ram_data_out=0xffffeeee and WAIT_RAM=1: ram_addr=1, bus_ready 2 cycles after acceptance, Cpu_data4bus=0xffffeeee, bus_err=0.
REQ-042 Write addr 0x00000008 with data 0xeeeeaaaa: data_ram_we high for exactly one cycle, ram_addr=2, ram_data_in=0xeeeeaaaa, then bus_ready.
REQ-043 Read 0xffff0210 with per_ack[1] after 3 cycles and per_rdata[63:32]=0x12345678: per_sel=0010, per_off=0x10, Cpu_data4bus=0x12345678.
REQ-044 Reads of 0xffff021a (misaligned) and 0x3c08ffff (unmapped): no strobes, bus_ready with bus_err=1, err_count increments by 2.
REQ-045 Read 0xffff0100 with no ack: per_sel[0] high for 15 cycles, then bus_err=1; a second run with ack on cycle 15 ends with no error.
REQ-046 rst=0 midway through a PER access: per_sel drops immediately, no bus_ready, and the next request is served normally.
